seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 202 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle integer ops and iterative
// multiply/divide (RISC-V M semantics), valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | ready for a request; single-cycle ops resolve on accept
// MUL   | shift-add multiply, one partial product per cycle
// DIV   | restoring divide on magnitudes, one quotient bit per cycle
// DONE  | result valid, held until the consumer takes it
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [4:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b01001;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic               neg_q, neg_r, dz;
  logic [2*WIDTH-1:0] sh_a;   // multiplicand (shifting) or divisor in low half
  logic [WIDTH-1:0]   sh_b;   // multiplier (shifting) or dividend/quotient
  logic [2*WIDTH-1:0] acc;    // product accumulator or remainder in low half

  logic               is_mul, is_div, last;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [2*WIDTH-1:0] acc_add, prod_fix;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH:0]     rem_sh, diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_n, quo_n, quo_fix, rem_fix, div_res;

  assign is_mul = (ctrl[4:3] == 2'b10) && !ctrl[2];
  assign is_div = (ctrl[4:3] == 2'b10) && ctrl[2];
  assign shamt  = op2[SW-1:0];
  assign last   = (cnt == CW'(1));

  // Single-cycle result; anything not decoded returns the illegal-op marker.
  always_comb begin
    alu_res = WIDTH'(16'hDEAD);
    case (ctrl)
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_SLL:  alu_res = op1 << shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SRL:  alu_res = op1 >> shamt;
      OP_SRA:  alu_res = $signed(op1) >>> shamt;
      OP_OR:   alu_res = op1 | op2;
      OP_AND:  alu_res = op1 & op2;
      default: alu_res = WIDTH'(16'hDEAD);
    endcase
  end

  // Operand signs and magnitudes at accept; the iterative engines work unsigned.
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    if (is_mul) begin
      a_neg = ((ctrl[1:0] == 2'b01) || (ctrl[1:0] == 2'b10)) && op1[WIDTH-1];
      b_neg = (ctrl[1:0] == 2'b01) && op2[WIDTH-1];
    end else if (is_div) begin
      a_neg = !ctrl[0] && op1[WIDTH-1];
      b_neg = !ctrl[0] && op2[WIDTH-1];
    end
    a_mag = a_neg ? -op1 : op1;
    b_mag = b_neg ? -op2 : op2;
  end

  // One multiply / divide step plus the sign fixup applied on the last step.
  always_comb begin
    acc_add  = acc + (sh_b[0] ? sh_a : '0);
    prod_fix = neg_q ? -acc_add : acc_add;
    mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    rem_sh   = {acc[WIDTH-1:0], sh_b[WIDTH-1]};
    diff     = rem_sh - {1'b0, sh_a[WIDTH-1:0]};
    ge       = !diff[WIDTH];
    rem_n    = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_n    = {sh_b[WIDTH-2:0], ge};
    // Divide by zero must give all ones even when the operand signs differ.
    quo_fix  = dz ? {WIDTH{1'b1}} : (neg_q ? -quo_n : quo_n);
    rem_fix  = neg_r ? -rem_n : rem_n;
    div_res  = op_q[1] ? rem_fix : quo_fix;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_mul)      state_nxt = MUL;
          else if (is_div) state_nxt = DIV;
          else             state_nxt = DONE;
        end
      end
      MUL, DIV: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      sh_a   <= '0;
      sh_b   <= '0;
      acc    <= '0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q  <= ctrl[2:0];
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          dz    <= (op2 == '0);
          cnt   <= CW'(WIDTH);
          acc   <= '0;
          if (is_mul) begin
            sh_a <= {{WIDTH{1'b0}}, a_mag};
            sh_b <= b_mag;
          end else if (is_div) begin
            sh_a <= {{WIDTH{1'b0}}, b_mag};
            sh_b <= a_mag;
          end else begin
            result <= alu_res;
            zero   <= (alu_res == '0);
          end
        end
        MUL: begin
          acc  <= acc_add;
          sh_a <= sh_a << 1;
          sh_b <= sh_b >> 1;
          cnt  <= cnt - CW'(1);
          if (last) begin
            result <= mul_res;
            zero   <= (mul_res == '0);
          end
        end
        DIV: begin
          acc  <= {{WIDTH{1'b0}}, rem_n};
          sh_b <= quo_n;
          cnt  <= cnt - CW'(1);
          if (last) begin
            result <= div_res;
            zero   <= (div_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu with hand-computed expected values.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1, op2;
  logic [4:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle, then scramble the inputs.
  task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    ctrl     = c;
    op1      = a;
    op2      = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ctrl     = ~c;
    op1      = $urandom;
    op2      = $urandom;
  endtask

  // Cycles from accept until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int elat);
    int lat;
    issue(c, a, b);
    wait_out(lat);
    check({tag, " lat"}, lat, elat);
    check({tag, " res"}, result, exp);
    check({tag, " zero"}, zero, (exp == 32'h0));
    @(posedge clk);
    #1;
    check({tag, " idle"}, out_valid, 1'b0);
  endtask

  initial begin
    int lat;
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op1       = '0;
    op2       = '0;
    ctrl      = '0;
    #12;
    check("rst out_valid", out_valid, 1'b0);
    check("rst result", result, 32'h0);
    check("rst zero", zero, 1'b1);
    check("rst in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("add",    5'b00000, 32'd5,        32'd7,        32'd12,       1);
    run_op("sub",    5'b01001, 32'd7,        32'd7,        32'd0,        1);
    run_op("slt1",   5'b00010, 32'h80000000, 32'hFFFFFFFF, 32'd1,        1);
    run_op("slt0",   5'b00010, 32'h00000001, 32'hFFFFFFFF, 32'd0,        1);
    run_op("sltu",   5'b00011, 32'h00000001, 32'hFFFFFFFF, 32'd1,        1);
    run_op("sra",    5'b01101, 32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 1);
    run_op("srl",    5'b00101, 32'h80000000, 32'h0000003F, 32'h00000001, 1);
    run_op("sll",    5'b00001, 32'h00000001, 32'h00000024, 32'h00000010, 1);
    run_op("xor",    5'b00100, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1);
    run_op("or",     5'b00110, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1);
    run_op("and",    5'b00111, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1);
    run_op("illegal",5'b11111, 32'd0,        32'd0,        32'h0000DEAD, 1);

    run_op("mulhu",  5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh",   5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mul",    5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_op("mul67",  5'b10000, 32'd6,        32'd7,        32'd42,       33);
    run_op("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);

    run_op("div0",   5'b10100, 32'd7,        32'd0,        32'hFFFFFFFF, 33);
    run_op("rem0",   5'b10110, 32'd7,        32'd0,        32'd7,        33);
    run_op("divn0",  5'b10100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 33);
    run_op("remn0",  5'b10110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 33);
    run_op("divovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run_op("removf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("divneg", 5'b10100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("remneg", 5'b10110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   5'b10101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   5'b10111, 32'd100,      32'd7,        32'd2,        33);
    run_op("divu0",  5'b10101, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 33);
    run_op("remu0",  5'b10111, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 33);

    // Backpressure: result must hold and new requests must be ignored.
    out_ready = 1'b0;
    issue(5'b00000, 32'd3, 32'd4);
    wait_out(lat);
    check("bp lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      ctrl     = 5'b00000;
      op1      = 32'd100;
      op2      = 32'd1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp out_valid", out_valid, 1'b1);
      check("bp result", result, 32'd7);
      check("bp zero", zero, 1'b0);
      check("bp in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release out_valid", out_valid, 1'b0);
    check("bp release in_ready", in_ready, 1'b1);
    check("bp release result", result, 32'd7);

    // Reset in the middle of a divide.
    issue(5'b10101, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort out_valid", out_valid, 1'b0);
    check("abort result", result, 32'h0);
    check("abort zero", zero, 1'b1);
    check("abort in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("post rst in_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort no pulse", seen, 1'b0);
    run_op("post rst add", 5'b00000, 32'd1, 32'd1, 32'd2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
